// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period.
package uart_pkg;

    // 50 MHz / 115200 baud
    localparam int unsigned UART_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: serial line in, FIFO read port out.
interface uart_rx_if;

    logic       Rx;
    logic       RxFifoRead;
    logic [7:0] RxData;
    logic       RxFifoEmpty;
    logic       RxFifoFull;
    logic       RxFrameError;
    logic       RxOverrun;

    modport slave (
        input  Rx,
        input  RxFifoRead,
        output RxData,
        output RxFifoEmpty,
        output RxFifoFull,
        output RxFrameError,
        output RxOverrun
    );

    modport master (
        output Rx,
        output RxFifoRead,
        input  RxData,
        input  RxFifoEmpty,
        input  RxFifoFull,
        input  RxFrameError,
        input  RxOverrun
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO; every entry usable thanks to the extra pointer wrap bit.
module uart_rx_fifo #(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic       clock,
    input  logic       nReset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] data,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [7:0]       mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    // Pointer comparison flags and the push/pop qualification
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
        do_pop  = pop && !empty;
        // a pop on a full FIFO frees the slot the push is about to overwrite
        do_push = push && (!full || do_pop);
    end

    assign data = mem[rd_ptr[FIFO_AW-1:0]];

    // Storage, pointers and the registered overflow pulse
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            mem      <= '{default: '0};
        end else begin
            overflow <= push && !do_push;
            if (do_push) begin
                mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM and receive FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FIFO_AW      = 4
) (
    input logic      clock,
    input logic      nReset,
    uart_rx_if.slave bus
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] HALF_TC = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_TC  = BAUD_W'(CLKS_PER_BIT - 1);

    logic              rx_meta;
    logic              rx_s;
    uart_rx_state_t    state;
    logic [BAUD_W-1:0] baud_counter;
    logic [2:0]        data_counter;
    logic [7:0]        shift_reg;
    logic              frame_error;
    logic              push;

    // Two-flop synchronizer, idles high so reset never looks like a start bit
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.Rx;
            rx_s    <= rx_meta;
        end
    end

    // Push happens on the stop-sample edge itself so the byte is visible one cycle later
    assign push = (state == ST_STOP) && (baud_counter == BIT_TC) && rx_s;

    // Frame recovery FSM with registered frame-error pulse
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state        <= ST_IDLE;
            baud_counter <= '0;
            data_counter <= '0;
            shift_reg    <= '0;
            frame_error  <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state        <= ST_START;
                        baud_counter <= '0;
                    end
                end
                ST_START: begin
                    if (baud_counter == HALF_TC) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            state        <= ST_DATA;
                            baud_counter <= '0;
                            data_counter <= '0;
                        end
                    end else begin
                        baud_counter <= baud_counter + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_counter == BIT_TC) begin
                        baud_counter            <= '0;
                        shift_reg[data_counter] <= rx_s;
                        data_counter            <= data_counter + 1'b1;
                        if (data_counter == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        baud_counter <= baud_counter + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_counter == BIT_TC) begin
                        baud_counter <= '0;
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= ST_BREAK;
                        end
                    end else begin
                        baud_counter <= baud_counter + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .FIFO_AW(FIFO_AW)
    ) u_fifo (
        .clock    (clock),
        .nReset   (nReset),
        .push     (push),
        .push_data(shift_reg),
        .pop      (bus.RxFifoRead),
        .data     (bus.RxData),
        .empty    (bus.RxFifoEmpty),
        .full     (bus.RxFifoFull),
        .overflow (bus.RxOverrun)
    );

    assign bus.RxFrameError = frame_error;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a queue-based reference model.
module tb_uart_rx;

    localparam int CLKS      = 21;
    localparam int AW        = 4;
    localparam int DEPTH     = 1 << AW;
    localparam int HALF      = CLKS / 2;
    // cycles from driving the start bit to the stop-sample edge (2 sync + 1 detect)
    localparam int STOP_EDGE = 3 + HALF + 9 * CLKS;

    logic clock = 1'b0;
    logic nReset = 1'b0;
    uart_rx_if bus();

    uart_rx #(
        .CLKS_PER_BIT(CLKS),
        .FIFO_AW     (AW)
    ) dut (
        .clock (clock),
        .nReset(nReset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int fe_cnt = 0, ov_cnt = 0;
    int exp_fe = 0, exp_ov = 0;
    int last_fe_cyc = -1, last_ov_cyc = -1, empty_fall_cyc = -1;
    logic prev_empty = 1'b1;
    logic [7:0] q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Pulse and empty-flag monitor, sampled away from the active edge
    always @(negedge clock) begin
        if (bus.RxFrameError) begin
            fe_cnt++;
            last_fe_cyc = cyc;
        end
        if (bus.RxOverrun) begin
            ov_cnt++;
            last_ov_cyc = cyc;
        end
        if (prev_empty && !bus.RxFifoEmpty) empty_fall_cyc = cyc;
        prev_empty = bus.RxFifoEmpty;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_empty"}, 32'(bus.RxFifoEmpty), 32'(q.size() == 0));
        check_eq({tag, "_full"}, 32'(bus.RxFifoFull), 32'(q.size() == DEPTH));
        if (q.size() > 0) check_eq({tag, "_data"}, 32'(bus.RxData), 32'(q[0]));
    endtask

    task automatic pop_byte();
        @(posedge clock); #1;
        bus.RxFifoRead = 1'b1;
        @(posedge clock); #1;
        bus.RxFifoRead = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        check_state("pop");
    endtask

    // Transmit one frame; optionally pop so the read lands on the stop-sample edge
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pop_at_stop);
        logic [9:0] bits;
        int idx;
        logic overrun_exp;
        bits = {stop_bit, b, 1'b0};
        overrun_exp = 1'b0;
        @(posedge clock); #1;
        start_cyc = cyc;
        for (int k = 0; k < 10 * CLKS; k++) begin
            idx = k / CLKS;
            bus.Rx = bits[idx[3:0]];
            bus.RxFifoRead = pop_at_stop && (k == STOP_EDGE - 1);
            @(posedge clock); #1;
        end
        bus.RxFifoRead = 1'b0;
        if (pop_at_stop && q.size() > 0) void'(q.pop_front());
        if (stop_bit) begin
            if (q.size() < DEPTH) q.push_back(b);
            else begin
                exp_ov++;
                overrun_exp = 1'b1;
            end
        end else begin
            exp_fe++;
            check_eq("fe_cycle", 32'(last_fe_cyc), 32'(start_cyc + STOP_EDGE));
        end
        if (overrun_exp) check_eq("ov_cycle", 32'(last_ov_cyc), 32'(start_cyc + STOP_EDGE));
    endtask

    initial begin
        repeat (200000) @(posedge clock);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int len;
        bus.Rx = 1'b1;
        bus.RxFifoRead = 1'b0;
        idle(3);
        check_eq("rst_empty", 32'(bus.RxFifoEmpty), 32'd1);
        check_eq("rst_full", 32'(bus.RxFifoFull), 32'd0);
        check_eq("rst_fe", 32'(bus.RxFrameError), 32'd0);
        check_eq("rst_ov", 32'(bus.RxOverrun), 32'd0);
        check_eq("rst_data", 32'(bus.RxData), 32'd0);
        nReset = 1'b1;
        idle(5);

        // two frames, then drain, then pop on empty
        send_frame(8'h55, 1'b1, 1'b0);
        check_eq("push_latency", 32'(empty_fall_cyc), 32'(start_cyc + STOP_EDGE));
        send_frame(8'hA3, 1'b1, 1'b0);
        check_state("two");
        pop_byte();
        pop_byte();
        pop_byte();

        // short low glitch must be rejected silently
        bus.Rx = 1'b0;
        idle(HALF - 3);
        bus.Rx = 1'b1;
        idle(HALF + 10);
        check_state("glitch");

        // bad stop bit with line held low: one frame error, then a clean frame
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(500);
        bus.Rx = 1'b1;
        idle(10);
        check_state("break");
        send_frame(8'h81, 1'b1, 1'b0);
        check_state("after_break");
        pop_byte();

        // fill past capacity
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            check_state("fill");
        end
        for (int i = 0; i < DEPTH; i++) pop_byte();

        // full FIFO with a pop on the stop-sample edge: no overrun
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 1'b0);
        send_frame(8'h77, 1'b1, 1'b1);
        check_state("pop_at_stop");
        check_eq("last_entry", 32'(q[q.size() - 1]), 32'h77);
        for (int i = 0; i < DEPTH; i++) pop_byte();

        // reset in the middle of data bit 4
        send_frame(8'h12, 1'b1, 1'b0);
        @(posedge clock); #1;
        b = 8'h5A;
        bus.Rx = 1'b0;
        idle(CLKS);
        for (int k = 0; k < 4; k++) begin
            bus.Rx = b[k];
            idle(CLKS);
        end
        bus.Rx = b[4];
        idle(HALF);
        nReset = 1'b0;
        #1;
        q.delete();
        check_eq("mid_rst_empty", 32'(bus.RxFifoEmpty), 32'd1);
        check_eq("mid_rst_full", 32'(bus.RxFifoFull), 32'd0);
        check_eq("mid_rst_data", 32'(bus.RxData), 32'd0);
        check_eq("mid_rst_fe", 32'(bus.RxFrameError), 32'd0);
        check_eq("mid_rst_ov", 32'(bus.RxOverrun), 32'd0);
        bus.Rx = 1'b1;
        idle(3);
        nReset = 1'b1;
        idle(2 * CLKS);
        check_state("post_rst");
        send_frame(8'hC6, 1'b1, 1'b0);
        check_state("after_rst");

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            len = int'($urandom_range(0, 9));
            if (len == 0) begin
                bus.Rx = 1'b0;
                idle(int'($urandom_range(1, HALF - 2)));
                bus.Rx = 1'b1;
                idle(HALF + 5);
            end else if (len == 1) begin
                send_frame(8'($urandom), 1'b0, 1'b0);
                idle(int'($urandom_range(0, 60)));
                bus.Rx = 1'b1;
                idle(5);
            end else begin
                send_frame(8'($urandom), 1'b1, 1'($urandom_range(0, 3) == 0));
            end
            check_state("rand");
            repeat ($urandom_range(0, 2)) pop_byte();
            idle(int'($urandom_range(0, 20)));
        end

        idle(5);
        check_eq("fe_count", 32'(fe_cnt), 32'(exp_fe));
        check_eq("ov_count", 32'(ov_cnt), 32'(exp_ov));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: recovers 8N1 frames from the asynchronous serial line `Rx` and buffers received bytes in a show-ahead FIFO for the host logic. It is the peer of the UART transmitter and shares its clock domain (50 MHz) and baud rate (115200). Framing errors and FIFO overruns are reported as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per bit period (50 MHz / 115200); minimum 4
- `FIFO_AW`, 4, FIFO address width; depth = 2^FIFO_AW bytes
- `clock`  in  1  system clock, rising-edge
- `nReset`  in  1  reset, asynchronous, active-low
- `Rx`  in  1  serial line, asynchronous, idle high
- `RxFifoRead`  in  1  pop head byte; ignored while `RxFifoEmpty`
- `RxData`  out  8  head byte of FIFO, valid while `!RxFifoEmpty`
- `RxFifoEmpty`  out  1  FIFO holds no bytes
- `RxFifoFull`  out  1  FIFO holds 2^FIFO_AW bytes
- `RxFrameError`  out  1  one-cycle pulse: stop bit sampled low
- `RxOverrun`  out  1  one-cycle pulse: good byte dropped, FIFO full

## Operation
- `Rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized value `rxS`.
- Bit counter `dataCounter` (3 bits), baud counter `baudCounter` (width $clog2(CLKS_PER_BIT)), shift register (8 bits, LSB first).
- States: IDLE, START, DATA, STOP, BREAK.
  - IDLE: `rxS`==0 -> START, clear `baudCounter`.
  - START: count to CLKS_PER_BIT/2 - 1 (integer division); at terminal count: if `rxS`==1 -> IDLE (glitch rejected, nothing reported), else -> DATA, clear counters.
  - DATA: count to CLKS_PER_BIT - 1; at terminal count shift `rxS` in at bit `dataCounter`, increment; after bit 7 -> STOP.
  - STOP: count to CLKS_PER_BIT - 1; at terminal count: `rxS`==1 -> push byte, -> IDLE; `rxS`==0 -> pulse `RxFrameError`, discard byte, -> BREAK.
  - BREAK: stay until `rxS`==1, then -> IDLE (a held-low line yields exactly one frame error).
  - Undefined encodings -> IDLE.
- FIFO: pointers are FIFO_AW+1 bits; empty when equal, full when MSBs differ and low bits equal. All 2^FIFO_AW entries usable.
- Push accepted if `!RxFifoFull` or a pop occurs in the same cycle; otherwise `RxOverrun` pulses and the byte is lost (stored data untouched).
- Pop when empty: no pointer change. Simultaneous push and pop when empty: push only (pop ignored).
- Reset: state IDLE, all counters and pointers 0, `RxFifoEmpty`=1, `RxFifoFull`=0, `RxFrameError`=0, `RxOverrun`=0, `RxData`=0 (storage cleared).
- Reset asserted mid-frame aborts the frame; no partial byte is pushed.

## Timing
- Sampling points: start bit at CLKS_PER_BIT/2 after falling edge seen on `rxS`; data bit n at that point + (n+1)·CLKS_PER_BIT; stop at + 9·CLKS_PER_BIT.
- Synchronizer delay: 2 cycles from `Rx` to `rxS`.
- Byte push at the stop-sample edge; `RxFifoEmpty` falls and `RxData` is valid in the next cycle.
- `RxFifoRead` sampled on rising edge; next head byte visible on `RxData` the cycle after (combinational read of storage at read pointer).
- `RxFrameError` and `RxOverrun` are registered; high for the cycle following the stop sample.
- Back-to-back frames: IDLE is re-entered at the stop sample (mid-stop-bit), so a start edge immediately after the stop bit is caught.

## Structure
- Package `uart_pkg`: state typedef `uart_rx_state_t`, constant `UART_CLKS_PER_BIT` = 434 (also used by the transmitter).
- Sub-module `uart_rx_fifo` (parameter FIFO_AW; push/pop/data/empty/full/overflow), reusable by the transmitter.

## Test plan
- Send 0x55 then 0xA3 at 434 clocks/bit -> `RxData`=0x55, `RxFifoEmpty` low; after one pop `RxData`=0xA3; second pop -> `RxFifoEmpty`=1.
- Rx low pulse of 100 clocks in IDLE -> no push, no `RxFrameError`, state back to IDLE.
- Frame 0x3C with stop bit low, line then held low 5000 clocks -> exactly one `RxFrameError` pulse, FIFO empty; next valid frame 0x81 received correctly.
- Send 17 bytes 0x00..0x10 without reading (FIFO_AW=4) -> `RxFifoFull`=1 after 16th, one `RxOverrun` pulse on 17th, pops return 0x00..0x0F.
- FIFO full, `RxFifoRead` asserted on the stop-sample cycle of byte 0x77 -> no overrun, 0x77 is last entry.
- `nReset` asserted at data bit 4 of a frame -> all outputs at reset values, no byte pushed; following frame 0xC6 received correctly.
